// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default rates, divider sizing helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DEF_CLK_FREQ = 12000000;
    localparam int DEF_BAUD     = 9600;
    localparam int DEF_OS_RATE  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

    // Clocks per oversampling tick, rounded to nearest.
    function automatic int os_div(input int clk_freq, input int baud, input int os_rate);
        return (clk_freq + (baud * os_rate) / 2) / (baud * os_rate);
    endfunction

    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversampling tick divider shared by the receive and transmit paths.
// Latency: os_tick high for one clk every DIV clks.
// Backpressure: none, runs continuously.
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int DIV = 78
) (
    input  logic clk,
    input  logic nrst,
    output logic os_tick
);

    localparam int W = div_width(DIV);

    logic [W-1:0] cnt;

    assign os_tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            cnt <= '0;
        end else if (os_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (8 data bits, optional even parity via UART_RX_PARITY_EN).
// Latency: rx_valid rises one clk after the os_tick that samples the stop-bit centre.
// Backpressure: one-byte holding register; a byte completing while it is full is dropped with an overrun pulse.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD,
    parameter int OS_RATE  = DEF_OS_RATE
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int DIV   = os_div(CLK_FREQ, BAUD, OS_RATE);
    localparam int CNT_W = div_width(OS_RATE);

    logic             os_tick;
    logic [1:0]       rx_sync;
    logic             rx_s;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] os_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             armed;
    logic             mid_pt, bit_end;
    logic             data_smp, stop_smp, byte_done, frame_bad, load, drop;
`ifdef UART_RX_PARITY_EN
    logic             par_smp, par_mis, par_bad;
`endif

    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .nrst    (nrst),
        .os_tick (os_tick)
    );

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rx};
        end
    end

    assign rx_s    = rx_sync[1];
    assign mid_pt  = (os_cnt == CNT_W'(OS_RATE / 2 - 1));
    assign bit_end = (os_cnt == CNT_W'(OS_RATE - 1));

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (os_tick) begin
            case (state)
                ST_IDLE:  if (!rx_s && armed) state_nxt = ST_START;
                ST_START: if (mid_pt) state_nxt = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
                ST_DATA:   if (bit_end && bit_cnt == 3'd7) state_nxt = ST_PARITY;
                ST_PARITY: if (bit_end) state_nxt = ST_STOP;
`else
                ST_DATA:  if (bit_end && bit_cnt == 3'd7) state_nxt = ST_STOP;
`endif
                ST_STOP:  if (bit_end) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data_smp  = os_tick && (state == ST_DATA) && bit_end;
        stop_smp  = os_tick && (state == ST_STOP) && bit_end;
        frame_bad = stop_smp && !rx_s;
`ifdef UART_RX_PARITY_EN
        par_smp   = os_tick && (state == ST_PARITY) && bit_end;
        par_mis   = par_smp && (rx_s != ^shift);
        byte_done = stop_smp && rx_s && !par_bad;
`else
        byte_done = stop_smp && rx_s;
`endif
        load      = byte_done && (!rx_valid || rx_ready);
        drop      = byte_done && rx_valid && !rx_ready;
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            armed   <= 1'b0;
        end else begin
            if (os_tick) begin
                if (state == ST_IDLE || state_nxt != state || bit_end) begin
                    os_cnt <= '0;
                end else begin
                    os_cnt <= os_cnt + 1'b1;
                end
            end
            if (state == ST_START) begin
                bit_cnt <= '0;
            end else if (data_smp) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (data_smp) begin
                shift <= {rx_s, shift[7:1]};
            end
            // A line stuck low must go high again before a new start bit counts.
            if (rx_s) begin
                armed <= 1'b1;
            end else if (frame_bad) begin
                armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= drop;
            if (load) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_mis;
            if (state == ST_START) begin
                par_bad <= 1'b0;
            end else if (par_mis) begin
                par_bad <= 1'b1;
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter CLK_FREQ, default 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter OS_RATE, default 16, oversampling ticks per bit.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port nrst  input  1  reset, asynchronous and active-high (1 = reset asserted).
REQ-006 Port rx  input  1  asynchronous serial line, idle high.
REQ-007 Port rx_data  output  8  received byte, valid while rx_valid=1.
REQ-008 Port rx_valid  output  1  holding register full.
REQ-009 Port rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready.
REQ-010 Port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-011 Port overrun  output  1  one-cycle pulse, completed byte dropped because holding register full.
REQ-012 Port parity_err  output  1  one-cycle pulse, parity mismatch.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use; synchronizer resets to 1.
REQ-014 Tick divider SHALL emit one-cycle os_tick every round(CLK_FREQ/(BAUD*OS_RATE)) clocks (78 at defaults); free-running counter, wraps to 0 after terminal count.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: synced rx low on an os_tick -> START, tick counter cleared.
REQ-017 START: at tick OS_RATE/2-1 (7) SHALL resample; low -> DATA, counter cleared; high -> IDLE (glitch rejected, no output).
REQ-018 DATA: sample every OS_RATE ticks at bit centre, shift LSB first into 8-bit register; after 8th bit -> PARITY if enabled, else STOP.
REQ-019 STOP: sample at centre; high -> byte completed; low -> frame_err pulse, byte discarded; both -> IDLE on same tick.
REQ-020 Byte completion with rx_valid=0, or rx_valid=1 and rx_ready=1 in same cycle: rx_data loaded, rx_valid=1 next cycle.
REQ-021 Byte completion with rx_valid=1 and rx_ready=0: overrun pulse, old rx_data retained.
REQ-022 rx_valid SHALL clear the cycle after rx_valid&&rx_ready when no new byte completes that cycle.
REQ-023 rx_data SHALL NOT change while rx_valid=1 except per REQ-020.
REQ-024 Latency: rx_valid rises exactly one clk after the os_tick sampling stop-bit centre.
REQ-025 Line held low continuously: frame_err once per frame; FSM re-enters START only after rx returns high then low.

Reset
REQ-026 nrst=1 SHALL immediately force: FSM=IDLE, counters 0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, synchronizer=1.
REQ-027 Reset mid-frame SHALL discard partial byte; after release, no output until a new valid start bit.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit after DATA; mismatch -> parity_err pulse, byte discarded, FSM still checks stop bit.
REQ-029 Macro undefined: PARITY state and logic absent, DATA -> STOP directly, parity_err tied 0.

Structure
REQ-030 Shared package uart_pkg SHALL hold FSM state enum, default CLK_FREQ/BAUD/OS_RATE constants, divider width computation.
REQ-031 Sub-module uart_os_tick SHALL implement the tick divider (REQ-014), reusable by transmit path.

Verification
REQ-032 Frame 0x53, 8N1, 9600 baud, rx_ready=1 -> rx_data=0x53, rx_valid one cycle, no error pulses.
REQ-033 rx low for 3 os_ticks then high -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-034 Frame 0xA5 with stop bit 0 -> frame_err one pulse, rx_valid stays 0.
REQ-035 Frames 0x11 then 0x22, rx_ready=0 -> rx_data=0x11, overrun one pulse at second stop; rx_ready=1 -> rx_valid drops.
REQ-036 nrst pulse during bit 4 of frame, then frame 0x6E -> only 0x6E delivered.
REQ-037 UART_RX_PARITY_EN: frame 0x70 with parity bit 0 (wrong) -> parity_err pulse, no rx_valid; parity bit 1 -> 0x70 delivered.
